// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide engine with stall/flush sequencing.
// One radix-2 step per cycle on unsigned magnitudes; signs are restored on the final step.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              sa_q, sa_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              accept, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   quo, rem, res_fin;

    assign a_signed = (op == 3'd1) | (op == 3'd2) | (op[2] & ~op[0]);
    assign b_signed = (op == 3'd1) | (op[2] & ~op[0]);
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];
    assign a_mag    = sa ? -a : a;
    assign b_mag    = sb ? -b : b;

    assign accept   = (state_q == IDLE) & start & ~kill;
    assign div_zero = (b == '0);
    assign div_ovf  = ~op[0] & (a == MIN_NEG) & (&b);
    assign fast     = op[2] & (div_zero | div_ovf);
    assign fast_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_NEG);

    // Multiply shifts the multiplier out of the low half; divide shifts the dividend up into the remainder.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign acc_step = op_q[2] ? (div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                              : {mul_sum, acc_q[XLEN-1:1]};

    assign prod     = neg_q ? -acc_step : acc_step;
    assign quo      = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign rem      = sa_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    assign res_fin  = op_q[2] ? (op_q[1] ? rem : quo)
                              : ((op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = (state_q == IDLE) ? (accept ? (fast ? DONE : BUSY) : IDLE)
                 : (state_q == BUSY) ? (kill ? IDLE : ((cnt_q == '0) ? DONE : BUSY))
                 : IDLE;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        cnt_d    = cnt_q;
        if (accept) begin
            op_d   = op;
            sa_d   = sa;
            neg_d  = sa ^ sb;
            cnt_d  = CW'(XLEN-1);
            acc_d  = {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
            opnd_d = op[2] ? b_mag : a_mag;
            if (fast) result_d = fast_res;
        end else if (state_q == BUSY && !kill) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) result_d = res_fin;
        end
    end

    always_comb begin
        stall  = accept | (state_q == BUSY);
        busy   = (state_q == BUSY);
        done   = (state_q == DONE);
        result = result_q;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized scoreboard bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clk, rst_n, start, kill;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        stall, busy, done;
    int          ec = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .kill(kill),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ec);
        end
    endtask

    function automatic logic [31:0] ref_model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        logic [63:0]        p;
        logic signed [63:0] sp;
        logic               ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return sp[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Called at a negedge while the DUT is idle; cut>0 aborts in that busy cycle by kill or reset.
    task automatic run(logic [2:0] o, logic [31:0] x, logic [31:0] y, int cut, bit use_rst);
        int lat;
        exp_t ex;
        lat = latency(o, x, y);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_result", result, last_res);
        start = 1; kill = 0; op = o; a = x; b = y;
        if (cut == 0) begin
            ex.res = ref_model(o, x, y);
            ex.at  = ec + lat;
            sb_q.push_back(ex);
        end
        #1 chk("stall_c0", stall, 1);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (cut != 0 && i == cut) begin
                chk("busy_at_cut", busy, 1);
                if (use_rst) begin
                    rst_n = 0; start = 0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_result", result, 0);
                    last_res = 0;
                    @(posedge clk);
                    #2 rst_n = 1;
                end else begin
                    kill = 1;
                    start = 1'($urandom_range(0, 1));
                end
                return;
            end
            chk("busy", busy, 32'(i < lat));
            chk("stall", stall, 32'(i < lat));
            chk("done", done, 32'(i == lat));
            start = 1'($urandom_range(0, 1));
            op = 3'($urandom); a = $urandom; b = $urandom;
        end
        last_res = ref_model(o, x, y);
    endtask

    task automatic both_idle();
        @(negedge clk);
        start = 1; kill = 1; op = 3'($urandom);
        #1 chk("start_kill_stall", stall, 0);
        @(negedge clk);
        chk("start_kill_busy", busy, 0);
        chk("start_kill_done", done, 0);
        start = 0; kill = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: result %0h at edge %0d, none expected", result, ec);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("done_edge", ec, e.at);
                end
            end
        end
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        int          sel, cut;
        bit          rs;
        rst_n = 0; start = 0; kill = 0; op = 0; a = 0; b = 0; last_res = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_stall", stall, 0);
        rst_n = 1;
        @(negedge clk) run(3'd0, 32'd7, 32'd6, 0, 0);
        @(negedge clk) run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk) run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk) run(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
        @(negedge clk) run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        @(negedge clk) run(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        @(negedge clk) run(3'd5, 32'h1234, 32'd0, 0, 0);
        @(negedge clk) run(3'd7, 32'h1234, 32'd0, 0, 0);
        @(negedge clk) run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk) run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk) run(3'd4, 32'd1000, 32'd7, 10, 0);
        @(negedge clk) run(3'd0, 32'd3, 32'd5, 0, 0);
        @(negedge clk) run(3'd4, 32'd1000, 32'd7, 15, 1);
        @(negedge clk) run(3'd0, 32'd9, 32'd9, 0, 0);
        both_idle();
        @(negedge clk) run(3'd5, 32'hDEAD_BEEF, 32'd13, 32, 0);
        for (int n = 0; n < 150; n++) begin
            o = 3'($urandom); x = $urandom; y = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel <= 3) begin x = $urandom_range(0, 255); y = $urandom_range(0, 15); end
            else if (sel == 4) begin x = 32'h8000_0000; end
            cut = 0; rs = 0;
            if (latency(o, x, y) == 33) begin
                sel = $urandom_range(0, 19);
                if (sel < 2) cut = $urandom_range(1, 32);
                else if (sel == 2) begin cut = $urandom_range(1, 32); rs = 1; end
            end
            sel = $urandom_range(0, 7);
            if (sel == 0) both_idle();
            else if (sel == 1) repeat (2) begin @(negedge clk); start = 0; kill = 0; end
            @(negedge clk) run(o, x, y, cut, rs);
        end
        @(negedge clk); start = 0; kill = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide engine and its sequencing FSM. It sits beside the EX-stage ALU and takes operands after forwarding. While an operation runs it holds a stall request to the hazard unit, then presents a one-cycle result. It handles RISC-V sign rules, divide-by-zero and signed overflow itself, and aborts on pipeline flush.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  EX holds an M-extension instruction; sampled only in IDLE.
op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
a  in  XLEN  rs1 operand, post-forwarding.
b  in  XLEN  rs2 operand, post-forwarding.
kill  in  1  EX flush (taken branch or jump); aborts the operation in flight.
stall  out  1  freeze IF/ID/EX to the hazard unit; combinational.
busy  out  1  state==BUSY, registered.
done  out  1  result valid, exactly one cycle.
result  out  XLEN  operation result; held until the next done.

Behaviour:
- Reset (async, rst_n low): state=IDLE, busy=0, done=0, result=0, counter and internal registers =0. Reset asserted mid-operation abandons it with no done.
- States: IDLE, BUSY, DONE.
- IDLE to BUSY: start=1 and kill=0 at the clock edge (cycle 0). Operands and op are latched, and magnitudes are taken of the signed operands: MULH a,b; MULHSU a only; DIV/REM a,b.
- IDLE to DONE (fast path, done in cycle 1), DIV/DIVU/REM/REMU only:
  - b==0: quotient=all ones; remainder=a.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient=0x80000000; remainder=0.
- BUSY:
  - One radix-2 step per cycle; counter runs from XLEN-1 down to 0.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - When counter==0, go to DONE with the sign-corrected value in result.
  - Normal latency: start sampled at cycle 0, busy for cycles 1..XLEN, done in cycle XLEN+1.
- Sign correction:
  - Product negated (2*XLEN bits) when the operand signs differ; MULHSU uses a's sign only.
  - Quotient negated when sign(a)!=sign(b).
  - Remainder takes sign(a).
- Result select: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU remainder.
- DONE: done=1 for one cycle, then IDLE unconditionally. kill in DONE has no effect; the consumer is being flushed anyway.
- stall = (state==IDLE & start & ~kill) | (state==BUSY). stall is 0 in DONE, so EX advances and captures result on the done cycle.
- kill in BUSY: next state IDLE, no done, result unchanged.
- kill and start together in IDLE: kill wins, nothing starts, stall=0.
- start while BUSY or DONE is ignored. A new op is accepted on the cycle after DONE at the earliest.
- All arithmetic is unsigned internally on XLEN-bit magnitudes. The minimum-negative magnitude is represented correctly as unsigned 2^(XLEN-1).

Test Plan:
- MUL a=7, b=6, start at cycle 0: stall high cycles 0..32, done=1 and result=42 at cycle 33, busy=0 at cycle 34.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF: result=0x00000000. MULHU same operands: result=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2: result=0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2: result=0xFFFFFFFD (-3). REM same operands: result=0xFFFFFFFF (-1). Both arrive at cycle 33.
- Fast paths:
  - DIVU a=0x1234, b=0: done at cycle 1, result=0xFFFFFFFF.
  - REMU same operands: result=0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF: done at cycle 1, result=0x80000000, busy never asserted.
- Abort: start DIV at cycle 0, kill at cycle 10. No done ever for that op, busy=0 at cycle 11, result unchanged. A new MUL 3*5 started at cycle 11 gives done with result=15 at cycle 44.
- rst_n pulled low at cycle 15 of a DIV: busy/done/result go to 0 immediately without a clock. After release, start=1 is accepted on the next edge. start and kill together in IDLE start nothing (stall=0).
